// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered, fixed-priority vectored interrupt controller that sequences the CPU PC source.
module int_ctrl #(
    parameter int              NIRQ       = 4,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int              VEC_STRIDE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            ei,
    input  logic            di,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_in,
    input  logic            reti,
    input  logic [PC_W-1:0] pc_in,
    output logic            int_take,
    output logic [PC_W-1:0] vec,
    output logic            ret_valid,
    output logic [PC_W-1:0] ret_pc,
    output logic            busy,
    output logic [NIRQ-1:0] pending
);
    localparam int ID_W = NIRQ > 1 ? $clog2(NIRQ) : 1;
    typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
    state_t          state, nxt;
    logic [NIRQ-1:0] irq_q, mask, elig, clr;
    logic [ID_W-1:0] id, win;
    logic            gie, start;
    assign elig = pending & mask;
    always_comb begin
        win = '0;
        for (int i = NIRQ - 1; i >= 0; i--) win = elig[i] ? ID_W'(i) : win;
    end
    always_comb begin
        start     = state == IDLE && gie && |elig;
        nxt       = start ? TAKE : state == TAKE ? SERVICE : (state == SERVICE && reti) ? IDLE : state;
        int_take  = state == TAKE;
        busy      = state == SERVICE;
        ret_valid = state == SERVICE && reti && !reset;
        vec       = int_take ? PC_W'(32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE)) : '0;
        clr       = int_take ? NIRQ'(1) << id : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            gie     <= 1'b0;
            id      <= '0;
            ret_pc  <= '0;
        end else begin
            state   <= nxt;
            irq_q   <= irq;
            // new edge ORed after the clear so a coincident edge keeps the bit
            pending <= (pending & ~clr) | (irq & ~irq_q);
            gie     <= (di || start) ? 1'b0 : (ei || ret_valid) ? 1'b1 : gie;
            if (mask_we) mask <= mask_in;
            if (start) id <= win;
            if (int_take) ret_pc <= pc_in;
        end
    end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Vectored interrupt controller for the single-cycle CPU.
- Edge-detects external interrupt lines, latches them as pending, applies mask and global-enable, and arbitrates by fixed priority.
- Sequences the datapath's PC source: forces a jump to the winning vector, holds the return address, and restores it on return-from-interrupt.
- Sits beside the control unit: control-unit decode drives ei/di/mask_we/reti; the datapath PC mux consumes int_take/vec and ret_valid/ret_pc.

Parameters:
- NIRQ, 4, number of interrupt lines (1..8).
- PC_W, 10, program-counter/program-memory address width.
- VEC_BASE, 10'h3C0, address of vector 0.
- VEC_STRIDE, 4, address spacing between consecutive vectors.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- irq  input  NIRQ  external request lines; rising edge requests service.
- ei  input  1  set global interrupt enable (gie).
- di  input  1  clear gie.
- mask_we  input  1  load mask from mask_in.
- mask_in  input  NIRQ  new mask value; 1 = line enabled.
- reti  input  1  return-from-interrupt decoded this cycle.
- pc_in  input  PC_W  address of the next sequential instruction (PC+1) from the datapath.
- int_take  output  1  one-cycle pulse: datapath loads PC with vec instead of PC+1.
- vec  output  PC_W  vector address of the winning line; 0 when int_take=0.
- ret_valid  output  1  one-cycle pulse: datapath loads PC with ret_pc.
- ret_pc  output  PC_W  saved return address.
- busy  output  1  high while an interrupt is in service.
- pending  output  NIRQ  latched pending bits.

Behaviour:
- Reset values: pending=0, mask=0, gie=0, irq_q=0, ret_pc=0, state=IDLE, int_take=0, ret_valid=0, busy=0, vec=0.
- Edge detection: irq_q<=irq every cycle.
  - pending[i] is set at a clock edge when irq[i]=1 and irq_q[i]=0.
  - irq is assumed already synchronous to clk.
- Qualification: eligible = pending & mask, considered only when gie=1.
- Arbitration: fixed priority, lowest index wins (id).
- Vector: vec = (VEC_BASE + id*VEC_STRIDE) mod 2^PC_W, driven only while int_take=1.
- gie register:
  - ei sets, di clears; di wins if both are asserted.
  - Entering TAKE clears gie.
  - The reti completion sets gie.
- mask_we updates the mask at the edge. A masked pending bit stays pending and is taken once unmasked.
- FSM, three states:
  - IDLE: busy=0. If gie and eligible!=0 at an edge, go to TAKE and register id.
  - TAKE: exactly one cycle. int_take=1, vec valid. At the end of TAKE:
    - ret_pc<=pc_in;
    - pending[id] is cleared;
    - go to SERVICE.
  - SERVICE: busy=1, no nesting, and new edges still latch into pending.
    - On reti: ret_valid=1 combinationally that cycle, with ret_pc held.
    - At that edge: go to IDLE and set gie.
    - A reti outside SERVICE is ignored: ret_valid stays 0.
- Latency:
  - An edge captured at edge E0 makes pending visible after E0.
  - With gie and mask set, int_take is high for the cycle after edge E1, i.e. 1 cycle later.
  - Back-to-back service: after the reti edge, a still-eligible pending line is taken at the next edge, so there is at least one IDLE cycle between services.
- Simultaneous events:
  - An edge on line id in the same cycle that pending[id] is cleared at TAKE end leaves the bit set; set wins.
  - ei together with reti completion: gie=1.
  - di together with reti completion: di wins.
  - mask_we during TAKE does not cancel the take in progress.
- Reset mid-operation (any state) returns to IDLE with all registers at reset values. The service in progress is discarded and ret_valid is not pulsed.

Test Plan:
- Reset, then ei and mask=4'b1111; raise irq[2] at cycle 5 -> pending=4'b0100 after edge 5, int_take=1 with vec=10'h3C8 in the cycle after edge 6, then busy=1 and pending=0.
- In TAKE with pc_in=10'h012, then reti 3 cycles later -> ret_valid=1 and ret_pc=10'h012 for exactly one cycle, then busy=0 and gie=1.
- Raise irq[3] and irq[1] in the same cycle -> line 1 served first (vec=10'h3C4); after reti and one IDLE cycle, line 3 served (vec=10'h3CC).
- mask=4'b1110, raise irq[0] -> pending[0]=1 and no int_take; write mask=4'b1111 -> int_take on the next edge with vec=10'h3C0.
- Hold irq[1] high continuously -> exactly one service (level ignored); gie=0 via di -> no take despite pending; reti while IDLE -> ret_valid stays 0.
- Assert reset during SERVICE -> next cycle busy=0, pending=0, ret_pc=0, gie=0, and no ret_valid pulse.
